// File: rtl/train_sensor_sim_if.sv
// Track-emulator bus: launch requests and switch states in, sensors and status out.
interface train_sensor_sim_if;
   logic        req;
   logic [1:0]  route;
   logic        switch2;
   logic        switch3;
   logic        sensor1;
   logic        sensor2;
   logic        sensor3;
   logic        busy;
   logic        done;
   logic        err;
   logic        ovf;
   logic [15:0] train_cnt;

   // Track controller side: launches trains, reports switch positions.
   modport master (
      output req, route, switch2, switch3,
      input  sensor1, sensor2, sensor3, busy, done, err, ovf, train_cnt
   );

   // Emulator side.
   modport slave (
      input  req, route, switch2, switch3,
      output sensor1, sensor2, sensor3, busy, done, err, ovf, train_cnt
   );
endinterface

// File: rtl/train_sensor_sim.sv
// Train passage emulator: drives entry/exit occupancy sensors for a track
// controller, waits for the required switch, counts completed trains and
// holds one pending launch request.
module train_sensor_sim #(
   parameter int unsigned OCC_CYCLES = 100,
   parameter int unsigned GAP_CYCLES = 50,
   parameter int unsigned TIMEOUT    = 1000
) (
   input  logic              clk,
   input  logic              rst,
   train_sensor_sim_if.slave bus
);

   typedef enum logic [2:0] {IDLE, ENTER, WAIT_SW, GAP, EXIT, DONE} state_t;

   localparam logic [1:0]  ROUTE_A = 2'b01;
   localparam logic [1:0]  ROUTE_B = 2'b10;
   localparam int unsigned MAX1    = (OCC_CYCLES > GAP_CYCLES) ? OCC_CYCLES : GAP_CYCLES;
   localparam int unsigned CNT_MAX = (MAX1 > TIMEOUT) ? MAX1 : TIMEOUT;
   localparam int unsigned CW      = $clog2(CNT_MAX + 1);

   localparam logic [CW-1:0] OCC_LAST = CW'(OCC_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
   localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    route_q, route_d;
   logic          pend_vld_q, pend_vld_d;
   logic [1:0]    pend_route_q, pend_route_d;
   logic          sensor1_q, sensor1_d;
   logic          sensor2_q, sensor2_d;
   logic          sensor3_q, sensor3_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          err_q, err_d;
   logic          ovf_q, ovf_d;
   logic [15:0]   train_cnt_q, train_cnt_d;

   logic          req_ok;
   logic          sw_ok;
   logic          leave;

   assign req_ok = bus.req & (^bus.route);
   assign sw_ok  = (route_q == ROUTE_A) ? bus.switch2 : bus.switch3;

   // Next-state, counter, pending buffer and registered-output decode.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      route_d      = route_q;
      pend_vld_d   = pend_vld_q;
      pend_route_d = pend_route_q;
      ovf_d        = ovf_q;
      err_d        = 1'b0;
      train_cnt_d  = train_cnt_q;
      leave        = 1'b0;

      case (state_q)
         IDLE: begin
            if (req_ok) begin
               state_d = ENTER;
               route_d = bus.route;
               cnt_d   = '0;
            end
         end
         ENTER: begin
            if (cnt_q == OCC_LAST) begin
               state_d = WAIT_SW;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         WAIT_SW: begin
            if (sw_ok) begin
               state_d = GAP;
               cnt_d   = '0;
            end else if (cnt_q == TO_LAST) begin
               err_d = 1'b1;
               leave = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         GAP: begin
            if (cnt_q == GAP_LAST) begin
               state_d = EXIT;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         EXIT: begin
            if (cnt_q == OCC_LAST) begin
               state_d     = DONE;
               cnt_d       = '0;
               train_cnt_d = train_cnt_q + 16'd1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         DONE: leave = 1'b1;
         default: state_d = IDLE;
      endcase

      // A request arriving in the cycle the train ends is treated like a
      // buffered one, so it never strands in the buffer while IDLE.
      if (state_q != IDLE) begin
         if (leave) begin
            cnt_d = '0;
            if (pend_vld_q) begin
               state_d    = ENTER;
               route_d    = pend_route_q;
               pend_vld_d = req_ok;
               if (req_ok) pend_route_d = bus.route;
            end else if (req_ok) begin
               state_d = ENTER;
               route_d = bus.route;
            end else begin
               state_d = IDLE;
            end
         end else if (req_ok) begin
            if (pend_vld_q) begin
               ovf_d = 1'b1;
            end else begin
               pend_vld_d   = 1'b1;
               pend_route_d = bus.route;
            end
         end
      end

      sensor1_d = (state_d == ENTER);
      sensor2_d = (state_d == EXIT) && (route_d == ROUTE_A);
      sensor3_d = (state_d == EXIT) && (route_d == ROUTE_B);
      busy_d    = (state_d != IDLE);
      done_d    = (state_d == DONE);
   end

   // State, counters and outputs, all cleared asynchronously by rst.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         route_q      <= '0;
         pend_vld_q   <= 1'b0;
         pend_route_q <= '0;
         sensor1_q    <= 1'b0;
         sensor2_q    <= 1'b0;
         sensor3_q    <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         ovf_q        <= 1'b0;
         train_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         route_q      <= route_d;
         pend_vld_q   <= pend_vld_d;
         pend_route_q <= pend_route_d;
         sensor1_q    <= sensor1_d;
         sensor2_q    <= sensor2_d;
         sensor3_q    <= sensor3_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         err_q        <= err_d;
         ovf_q        <= ovf_d;
         train_cnt_q  <= train_cnt_d;
      end
   end

   assign bus.sensor1   = sensor1_q;
   assign bus.sensor2   = sensor2_q;
   assign bus.sensor3   = sensor3_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.err       = err_q;
   assign bus.ovf       = ovf_q;
   assign bus.train_cnt = train_cnt_q;

endmodule

// File: tb/tb_train_sensor_sim.sv
// Bench for train_sensor_sim: directed scenarios then random traffic, each
// cycle compared against a timestamp-based model of train passages.
module tb_train_sensor_sim;

   localparam int OCC_C = 4;
   localparam int GAP_C = 2;
   localparam int TO_C  = 8;

   logic clk = 1'b0;
   logic rst = 1'b0;

   train_sensor_sim_if bus ();

   train_sensor_sim #(
      .OCC_CYCLES(OCC_C),
      .GAP_CYCLES(GAP_C),
      .TIMEOUT   (TO_C)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // model: current train as timestamps (t0 = first sensor1 cycle,
   // tsw = cycle the switch was seen open, -1 until then)
   bit         m_active;
   logic [1:0] m_route;
   int         m_t0;
   int         m_tsw;
   logic [1:0] m_pend[$];
   bit         m_ovf;
   bit         m_err;
   logic [15:0] m_cnt;
   bit e_s1, e_s2, e_s3, e_busy, e_done;

   // observation statistics for directed checks
   int n_err, n_done, n_s1, n_s2, err_cyc, s1_rise, s3_rise, first_done;
   bit prev_s1, prev_s3;
   int t_raise, t_wait;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic launch(input int t, input logic [1:0] r);
      m_active = 1'b1;
      m_route  = r;
      m_t0     = t;
      m_tsw    = -1;
   endtask

   task automatic model_reset();
      m_active = 1'b0;
      m_pend.delete();
      m_ovf = 1'b0;
      m_err = 1'b0;
      m_cnt = '0;
      e_s1 = 0; e_s2 = 0; e_s3 = 0; e_busy = 0; e_done = 0;
   endtask

   // Called at a clock edge: inputs seen now belong to cycle cyc; the
   // expectations produced are for cycle cyc+1.
   task automatic model_edge();
      int  k;
      int  w;
      int  n;
      bit  sw;
      bit  valid;
      bit  fin;
      bit  ex;
      k     = cyc;
      valid = bus.req && (bus.route == 2'b01 || bus.route == 2'b10);
      fin   = 1'b0;
      m_err = 1'b0;
      if (m_active) begin
         w  = m_t0 + OCC_C;
         sw = (m_route == 2'b01) ? bus.switch2 : bus.switch3;
         if (m_tsw < 0 && k >= w) begin
            if (sw) m_tsw = k;
            else if (k == w + TO_C - 1) begin
               m_err = 1'b1;
               fin   = 1'b1;
            end
         end
         if (m_tsw >= 0 && k == m_tsw + GAP_C + OCC_C + 1) fin = 1'b1;
      end
      if (!m_active) begin
         if (valid) launch(k + 1, bus.route);
      end else if (fin) begin
         m_active = 1'b0;
         if (m_pend.size() > 0) begin
            launch(k + 1, m_pend.pop_front());
            if (valid) m_pend.push_back(bus.route);
         end else if (valid) begin
            launch(k + 1, bus.route);
         end
      end else if (valid) begin
         if (m_pend.size() == 0) m_pend.push_back(bus.route);
         else m_ovf = 1'b1;
      end
      cyc = k + 1;
      n   = cyc;
      e_s1   = m_active && n >= m_t0 && n < m_t0 + OCC_C;
      ex     = m_active && m_tsw >= 0 && n > m_tsw + GAP_C && n <= m_tsw + GAP_C + OCC_C;
      e_s2   = ex && m_route == 2'b01;
      e_s3   = ex && m_route == 2'b10;
      e_done = m_active && m_tsw >= 0 && n == m_tsw + GAP_C + OCC_C + 1;
      if (e_done) m_cnt = m_cnt + 16'd1;
      e_busy = m_active;
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      chk("sensor1",   32'(bus.sensor1),   32'(e_s1));
      chk("sensor2",   32'(bus.sensor2),   32'(e_s2));
      chk("sensor3",   32'(bus.sensor3),   32'(e_s3));
      chk("busy",      32'(bus.busy),      32'(e_busy));
      chk("done",      32'(bus.done),      32'(e_done));
      chk("err",       32'(bus.err),       32'(m_err));
      chk("ovf",       32'(bus.ovf),       32'(m_ovf));
      chk("train_cnt", 32'(bus.train_cnt), 32'(m_cnt));
      chk("one_sensor", 32'($countones({bus.sensor1, bus.sensor2, bus.sensor3}) <= 1), 32'(1));
      if (bus.err === 1'b1) begin n_err++; err_cyc = cyc; end
      if (bus.done === 1'b1) begin
         n_done++;
         if (first_done < 0) first_done = cyc;
      end
      if (bus.sensor1 === 1'b1) begin
         n_s1++;
         if (!prev_s1) s1_rise = cyc;
      end
      if (bus.sensor2 === 1'b1) n_s2++;
      if (bus.sensor3 === 1'b1 && !prev_s3) s3_rise = cyc;
      prev_s1 = (bus.sensor1 === 1'b1);
      prev_s3 = (bus.sensor3 === 1'b1);
   endtask

   task automatic clr_stats();
      n_err = 0; n_done = 0; n_s1 = 0; n_s2 = 0;
      err_cyc = -1; s1_rise = -1; s3_rise = -1; first_done = -1;
      prev_s1 = 1'b0; prev_s3 = 1'b0;
   endtask

   // Asserts rst mid-cycle, checks outputs cleared before any clock edge,
   // then releases it just after an edge.
   task automatic do_reset();
      #2;
      rst = 1'b1;
      #1;
      chk("rst_sensor1",   32'(bus.sensor1),   32'(0));
      chk("rst_sensor2",   32'(bus.sensor2),   32'(0));
      chk("rst_sensor3",   32'(bus.sensor3),   32'(0));
      chk("rst_busy",      32'(bus.busy),      32'(0));
      chk("rst_done",      32'(bus.done),      32'(0));
      chk("rst_err",       32'(bus.err),       32'(0));
      chk("rst_ovf",       32'(bus.ovf),       32'(0));
      chk("rst_train_cnt", 32'(bus.train_cnt), 32'(0));
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      bus.req = 1'b0; bus.route = 2'b00; bus.switch2 = 1'b0; bus.switch3 = 1'b0;
      do_reset();

      // route A, switch2 open throughout
      clr_stats();
      bus.switch2 = 1'b1;
      bus.req = 1'b1; bus.route = 2'b01; step(); bus.req = 1'b0;
      repeat (18) step();
      chk("a_s1_cycles", 32'(n_s1), 32'(OCC_C));
      chk("a_s2_cycles", 32'(n_s2), 32'(OCC_C));
      chk("a_done_cnt",  32'(n_done), 32'(1));
      chk("a_train_cnt", 32'(bus.train_cnt), 32'(1));
      chk("a_busy_end",  32'(bus.busy), 32'(0));

      // route B, switch3 raised 5 cycles into WAIT_SW
      do_reset(); clr_stats();
      bus.switch2 = 1'b0; bus.switch3 = 1'b0;
      bus.req = 1'b1; bus.route = 2'b10; step(); bus.req = 1'b0;
      repeat (OCC_C) step();
      repeat (5) step();
      bus.switch3 = 1'b1; t_raise = cyc;
      repeat (12) step();
      chk("b_no_err",    32'(n_err), 32'(0));
      chk("b_s3_rise",   32'(s3_rise), 32'(t_raise + GAP_C + 1));
      chk("b_train_cnt", 32'(bus.train_cnt), 32'(1));

      // route A with switch2 closed: timeout
      do_reset(); clr_stats();
      bus.switch2 = 1'b0; bus.switch3 = 1'b1;
      bus.req = 1'b1; bus.route = 2'b01; step(); bus.req = 1'b0;
      t_wait = cyc + OCC_C;
      repeat (20) step();
      chk("to_err_cnt",   32'(n_err), 32'(1));
      chk("to_err_cyc",   32'(err_cyc), 32'(t_wait + TO_C));
      chk("to_no_s2",     32'(n_s2), 32'(0));
      chk("to_train_cnt", 32'(bus.train_cnt), 32'(0));
      chk("to_busy_end",  32'(bus.busy), 32'(0));

      // three requests back to back: run, buffer, drop
      do_reset(); clr_stats();
      bus.switch2 = 1'b1; bus.switch3 = 1'b1;
      bus.req = 1'b1; bus.route = 2'b01; step();
      bus.route = 2'b10; step();
      bus.route = 2'b01; step();
      bus.req = 1'b0;
      repeat (40) step();
      chk("q_ovf",        32'(bus.ovf), 32'(1));
      chk("q_done_cnt",   32'(n_done), 32'(2));
      chk("q_train_cnt",  32'(bus.train_cnt), 32'(2));
      chk("q_back2back",  32'(s1_rise), 32'(first_done + 1));
      chk("q_busy_end",   32'(bus.busy), 32'(0));

      // reset during EXIT, then a clean train
      do_reset(); clr_stats();
      bus.switch2 = 1'b1;
      bus.req = 1'b1; bus.route = 2'b01; step(); bus.req = 1'b0;
      for (int i = 0; i < 20 && bus.sensor2 !== 1'b1; i++) step();
      chk("x_in_exit", 32'(bus.sensor2), 32'(1));
      step();
      do_reset(); clr_stats();
      bus.req = 1'b1; bus.route = 2'b01; step(); bus.req = 1'b0;
      repeat (16) step();
      chk("x_done_cnt",  32'(n_done), 32'(1));
      chk("x_no_err",    32'(n_err), 32'(0));
      chk("x_train_cnt", 32'(bus.train_cnt), 32'(1));

      // invalid routes in IDLE are ignored
      do_reset(); clr_stats();
      bus.req = 1'b1; bus.route = 2'b11; repeat (5) step();
      bus.route = 2'b00; repeat (3) step();
      bus.req = 1'b0; step();
      chk("inv_busy", 32'(bus.busy), 32'(0));
      chk("inv_s1",   32'(n_s1), 32'(0));
      chk("inv_ovf",  32'(bus.ovf), 32'(0));

      // random traffic: sparse then dense requests, flickering switches
      do_reset(); clr_stats();
      for (int i = 0; i < 800; i++) begin
         bus.req     = ($urandom_range(0, (i < 400) ? 15 : 2) == 0);
         bus.route   = 2'($urandom_range(0, 3));
         bus.switch2 = ($urandom_range(0, 4) == 0);
         bus.switch3 = ($urandom_range(0, 4) == 0);
         step();
         if (i == 400) do_reset();
      end
      bus.req = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
